// File: rtl/apbdma_pkg.sv
// Shared types for the APB DMA narrow-to-wide upsize scheduler.
// Holds the FSM state encoding and the lane-ratio helper.
package apbdma_pkg;

   typedef enum logic [1:0] {
      Idle    = 2'd0,
      Collect = 2'd1,
      Send    = 2'd2
   } state_t;

   function automatic int ratio_of(input int in_w, input int out_w);
      return out_w / in_w;
   endfunction

endpackage

// File: rtl/apbdma_rr_pick.sv
// Round-robin picker: first valid requester at or above the pointer,
// wrapping, returned as a one-hot grant and a binary index.
module apbdma_rr_pick #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  valid,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] idx
);

   logic [IW:0] sum;
   logic        found;

   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      sum   = '0;
      for (int k = 0; k < N; k++) begin
         // ptr < N, so one subtraction is enough to wrap
         sum = {1'b0, ptr} + (IW + 1)'(k);
         if (sum >= (IW + 1)'(N)) sum = sum - (IW + 1)'(N);
         if (!found && valid[sum[IW-1:0]]) begin
            found              = 1'b1;
            grant[sum[IW-1:0]] = 1'b1;
            idx                = sum[IW-1:0];
         end
      end
   end

endmodule

// File: rtl/apbdma_upsize_sched.sv
// Packs narrow beats from a round-robin chosen requester into one wide
// word tagged with the requester ID; the grant is locked for the word.
module apbdma_upsize_sched
   import apbdma_pkg::*;
#(
   parameter int   NumReq       = 4,
   parameter int   InDataWidth  = 32,
   parameter int   OutDataWidth = 64,
   localparam int  IdWidth      = $clog2(NumReq)
) (
   input  logic                                  clk_i,
   input  logic                                  rst_ni,
   input  logic [NumReq-1:0][InDataWidth-1:0]    req_data_i,
   input  logic [NumReq-1:0][InDataWidth/8-1:0]  req_strb_i,
   input  logic [NumReq-1:0]                     req_last_i,
   input  logic [NumReq-1:0]                     req_valid_i,
   output logic [NumReq-1:0]                     req_ready_o,
   output logic [OutDataWidth-1:0]               data_o,
   output logic [OutDataWidth/8-1:0]             strb_o,
   output logic [IdWidth-1:0]                    id_o,
   output logic                                  last_o,
   output logic                                  valid_o,
   input  logic                                  ready_i
);

   localparam int Ratio     = ratio_of(InDataWidth, OutDataWidth);
   localparam int StrbWidth = InDataWidth / 8;
   localparam int OutStrb   = OutDataWidth / 8;
   localparam int CntWidth  = $clog2(Ratio);

   state_t                     state;
   logic [CntWidth-1:0]        cnt;
   logic [IdWidth-1:0]         ptr;
   logic [IdWidth-1:0]         gid;
   logic [OutDataWidth-1:0]    data_q;
   logic [OutStrb-1:0]         strb_q;
   logic                       last_q;
   logic                       valid_q;

   logic [NumReq-1:0]          pick_grant;
   logic [IdWidth-1:0]         pick_idx;
   logic [IdWidth-1:0]         sel;
   logic [NumReq-1:0]          ready_vec;
   logic                       xfer;
   logic [InDataWidth-1:0]     beat_data;
   logic [StrbWidth-1:0]       beat_strb;
   logic                       beat_last;

   apbdma_rr_pick #(
      .N  (NumReq),
      .IW (IdWidth)
   ) u_pick (
      .valid (req_valid_i),
      .ptr   (ptr),
      .grant (pick_grant),
      .idx   (pick_idx)
   );

   // Idle grant is gated by reset so ready stays low while held in reset
   always_comb begin
      ready_vec = '0;
      unique case (state)
         Idle:    ready_vec = pick_grant & {NumReq{rst_ni}};
         Collect: ready_vec = NumReq'(1) << gid;
         default: ready_vec = '0;
      endcase
   end

   assign sel       = (state == Collect) ? gid : pick_idx;
   assign beat_data = req_data_i[sel];
   assign beat_strb = req_strb_i[sel];
   assign beat_last = req_last_i[sel];
   assign xfer      = |(ready_vec & req_valid_i);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state   <= Idle;
         cnt     <= '0;
         ptr     <= '0;
         gid     <= '0;
         data_q  <= '0;
         strb_q  <= '0;
         last_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         unique case (state)
            Idle: begin
               if (xfer) begin
                  data_q <= OutDataWidth'(beat_data);
                  strb_q <= OutStrb'(beat_strb);
                  gid    <= pick_idx;
                  cnt    <= CntWidth'(1);
                  last_q <= beat_last;
                  if (beat_last) begin
                     state   <= Send;
                     valid_q <= 1'b1;
                  end else begin
                     state <= Collect;
                  end
               end
            end
            Collect: begin
               if (xfer) begin
                  for (int l = 0; l < Ratio; l++) begin
                     if (cnt == CntWidth'(l)) begin
                        data_q[l*InDataWidth +: InDataWidth] <= beat_data;
                        strb_q[l*StrbWidth +: StrbWidth]     <= beat_strb;
                     end
                  end
                  cnt    <= cnt + CntWidth'(1);
                  last_q <= beat_last;
                  if (beat_last || cnt == CntWidth'(Ratio - 1)) begin
                     state   <= Send;
                     valid_q <= 1'b1;
                  end
               end
            end
            Send: begin
               if (ready_i) begin
                  state   <= Idle;
                  valid_q <= 1'b0;
                  cnt     <= '0;
                  ptr     <= (gid == IdWidth'(NumReq - 1)) ?
                             '0 : gid + IdWidth'(1);
               end
            end
            default: state <= Idle;
         endcase
      end
   end

   assign req_ready_o = ready_vec;
   assign data_o      = data_q;
   assign strb_o      = strb_q;
   assign id_o        = gid;
   assign last_o      = last_q;
   assign valid_o     = valid_q;

endmodule

// File: tb/tb_apbdma_upsize_sched.sv
// Scoreboard bench for apbdma_upsize_sched: a beat driver, a word
// monitor and directed sequences with hand-computed wide words.
module tb_apbdma_upsize_sched;

   localparam int N = 4;

   typedef struct {
      logic [31:0] d;
      logic [3:0]  s;
      logic        l;
   } beat_t;

   typedef struct {
      logic [63:0] d;
      logic [7:0]  s;
      logic [1:0]  id;
      logic        l;
   } word_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   logic [N-1:0][31:0] req_data  = '0;
   logic [N-1:0][3:0]  req_strb  = '0;
   logic [N-1:0]       req_last  = '0;
   logic [N-1:0]       req_valid = '0;
   logic [N-1:0]       req_ready;
   logic [63:0]        data;
   logic [7:0]         strb;
   logic [1:0]         id;
   logic               last;
   logic               valid;
   logic               ready_in = 1'b1;

   beat_t       bq[N][$];
   word_t       exp_q[$];
   word_t       e;
   int          checks   = 0;
   int          errors   = 0;
   int          cyc      = 0;
   int          xfer_cyc = 0;
   logic        valid_prev = 1'b0;
   logic [N-1:0] took;

   logic [63:0] hold_d;
   logic [7:0]  hold_s;
   logic [1:0]  hold_id;
   logic        hold_l;

   apbdma_upsize_sched #(
      .NumReq       (N),
      .InDataWidth  (32),
      .OutDataWidth (64)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .req_data_i  (req_data),
      .req_strb_i  (req_strb),
      .req_last_i  (req_last),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready),
      .data_o      (data),
      .strb_o      (strb),
      .id_o        (id),
      .last_o      (last),
      .valid_o     (valid),
      .ready_i     (ready_in)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Beat driver: present queue heads at negedge, sample just before posedge
   always begin
      @(negedge clk);
      for (int g = 0; g < N; g++) begin
         if (bq[g].size() > 0) begin
            req_valid[g] = 1'b1;
            req_data[g]  = bq[g][0].d;
            req_strb[g]  = bq[g][0].s;
            req_last[g]  = bq[g][0].l;
         end else begin
            req_valid[g] = 1'b0;
            req_data[g]  = '0;
            req_strb[g]  = '0;
            req_last[g]  = 1'b0;
         end
      end
      #4;
      took = req_valid & req_ready;
      if (took != '0) xfer_cyc = cyc;
      @(posedge clk);
      for (int g = 0; g < N; g++)
         if (took[g]) void'(bq[g].pop_front());
   end

   // Word monitor
   always begin
      @(negedge clk);
      #4;
      chk("ready_onehot", 64'($onehot0(req_ready)), 64'd1);
      if (valid && !valid_prev)
         chk("latency", 64'(cyc), 64'(xfer_cyc + 1));
      valid_prev = valid;
      if (valid && ready_in) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got id %0d data %h expected none",
                     id, data);
         end else begin
            e = exp_q.pop_front();
            chk("data", data, e.d);
            chk("strb", 64'(strb), 64'(e.s));
            chk("id", 64'(id), 64'(e.id));
            chk("last", 64'(last), 64'(e.l));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_beat(input int g, input logic [31:0] d,
                            input logic [3:0] s, input logic l);
      beat_t b;
      b.d = d;
      b.s = s;
      b.l = l;
      bq[g].push_back(b);
   endtask

   task automatic expect_word(input logic [63:0] d, input logic [7:0] s,
                              input logic [1:0] i, input logic l);
      word_t w;
      w.d  = d;
      w.s  = s;
      w.id = i;
      w.l  = l;
      exp_q.push_back(w);
   endtask

   function automatic bit pending();
      bit p = 1'b0;
      for (int g = 0; g < N; g++)
         if (bq[g].size() != 0) p = 1'b1;
      return p;
   endfunction

   task automatic drain(input int maxc);
      int n = 0;
      while ((exp_q.size() != 0 || pending()) && n < maxc) begin
         step();
         n++;
      end
      if (exp_q.size() != 0 || pending()) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: got %0d words left expected 0",
                  exp_q.size());
         exp_q.delete();
         for (int g = 0; g < N; g++) bq[g].delete();
      end
      step();
   endtask

   task automatic wait_taken(input int g, input int maxc);
      int n = 0;
      while (bq[g].size() != 0 && n < maxc) begin
         step();
         n++;
      end
      if (bq[g].size() != 0) begin
         checks++;
         errors++;
         $display("FAIL take_timeout: got req%0d beat pending expected taken",
                  g);
         bq[g].delete();
      end
   endtask

   task automatic wait_valid(input int maxc);
      int n = 0;
      while (!valid && n < maxc) begin
         step();
         n++;
      end
      if (!valid) begin
         checks++;
         errors++;
         $display("FAIL valid_timeout: got valid 0 expected 1");
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      step();
   endtask

   initial begin
      ready_in = 1'b1;
      rst_n    = 1'b0;
      repeat (3) step();
      chk("rst_valid", 64'(valid), 64'd0);
      chk("rst_ready", 64'(req_ready), 64'd0);
      chk("rst_data", data, 64'd0);
      chk("rst_strb", 64'(strb), 64'd0);
      chk("rst_id", 64'(id), 64'd0);
      chk("rst_last", 64'(last), 64'd0);
      rst_n = 1'b1;
      step();

      // Full word from req1
      push_beat(1, 32'h11111111, 4'hF, 1'b0);
      push_beat(1, 32'h22222222, 4'hF, 1'b0);
      expect_word(64'h22222222_11111111, 8'hFF, 2'd1, 1'b0);
      drain(30);

      // Early last flushes a half word
      push_beat(2, 32'hAAAA5555, 4'hF, 1'b1);
      expect_word(64'h00000000_AAAA5555, 8'h0F, 2'd2, 1'b1);
      drain(30);

      // All four valid: ids 0,1,2,3,0; zero-strobe beat still takes a lane
      do_reset();
      push_beat(0, 32'hA0000001, 4'hF, 1'b0);
      push_beat(0, 32'hA0000002, 4'hF, 1'b0);
      push_beat(0, 32'hA0000003, 4'hF, 1'b0);
      push_beat(0, 32'hA0000004, 4'hF, 1'b1);
      push_beat(1, 32'hB1000001, 4'hF, 1'b0);
      push_beat(1, 32'hB1000002, 4'hF, 1'b0);
      push_beat(2, 32'hC2000001, 4'hF, 1'b0);
      push_beat(2, 32'hC2000002, 4'h0, 1'b0);
      push_beat(3, 32'hD3000001, 4'hF, 1'b0);
      push_beat(3, 32'hD3000002, 4'hF, 1'b0);
      expect_word(64'hA0000002_A0000001, 8'hFF, 2'd0, 1'b0);
      expect_word(64'hB1000002_B1000001, 8'hFF, 2'd1, 1'b0);
      expect_word(64'hC2000002_C2000001, 8'h0F, 2'd2, 1'b0);
      expect_word(64'hD3000002_D3000001, 8'hFF, 2'd3, 1'b0);
      expect_word(64'hA0000004_A0000003, 8'hFF, 2'd0, 1'b1);
      drain(80);

      // Grant locked on req0 while req3 waits
      push_beat(0, 32'h01010101, 4'hF, 1'b0);
      wait_taken(0, 20);
      push_beat(3, 32'h33330001, 4'hF, 1'b0);
      push_beat(3, 32'h33330002, 4'hF, 1'b1);
      repeat (3) begin
         step();
         chk("req3_locked", 64'(req_ready[3]), 64'd0);
         chk("collect_valid", 64'(valid), 64'd0);
      end
      push_beat(0, 32'h02020202, 4'hF, 1'b0);
      expect_word(64'h02020202_01010101, 8'hFF, 2'd0, 1'b0);
      expect_word(64'h33330002_33330001, 8'hFF, 2'd3, 1'b1);
      drain(40);

      // Downstream stall holds the word
      ready_in = 1'b0;
      push_beat(1, 32'h55550001, 4'h3, 1'b0);
      push_beat(1, 32'h55550002, 4'hC, 1'b0);
      expect_word(64'h55550002_55550001, 8'hC3, 2'd1, 1'b0);
      wait_valid(20);
      push_beat(2, 32'h99990001, 4'hF, 1'b1);
      expect_word(64'h00000000_99990001, 8'h0F, 2'd2, 1'b1);
      hold_d  = data;
      hold_s  = strb;
      hold_id = id;
      hold_l  = last;
      repeat (5) begin
         step();
         chk("stall_valid", 64'(valid), 64'd1);
         chk("stall_data", data, hold_d);
         chk("stall_strb", 64'(strb), 64'(hold_s));
         chk("stall_id", 64'(id), 64'(hold_id));
         chk("stall_last", 64'(last), 64'(hold_l));
         chk("stall_ready", 64'(req_ready), 64'd0);
      end
      ready_in = 1'b1;
      drain(40);

      // Reset mid-word drops the partial word and the RR pointer
      push_beat(1, 32'h66660001, 4'hF, 1'b1);
      expect_word(64'h00000000_66660001, 8'h0F, 2'd1, 1'b1);
      drain(30);
      push_beat(0, 32'hDEAD0001, 4'hF, 1'b0);
      wait_taken(0, 20);
      step();
      rst_n = 1'b0;
      step();
      chk("midrst_valid", 64'(valid), 64'd0);
      chk("midrst_data", data, 64'd0);
      step();
      rst_n = 1'b1;
      step();
      push_beat(0, 32'h77770001, 4'hF, 1'b0);
      push_beat(0, 32'h77770002, 4'hF, 1'b0);
      push_beat(2, 32'h88880001, 4'hF, 1'b1);
      expect_word(64'h77770002_77770001, 8'hFF, 2'd0, 1'b0);
      expect_word(64'h00000000_88880001, 8'h0F, 2'd2, 1'b1);
      drain(40);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/apbdma_upsize_sched.md
Name: apbdma_upsize_sched

Overview:
Shares one narrow-to-wide packing datapath among NumReq narrow requesters (e.g. per-channel APB read streams in the DMA). It picks one requester by round-robin and locks the grant for a whole wide word. Narrow beats are packed lane by lane, lowest lane first. One wide word is emitted, tagged with the requester ID. A requester-side last flag flushes a partially filled word early.

Parameters:
NumReq, 4, number of narrow requesters; must be >= 2
InDataWidth, 32, narrow beat width in bits; must be a multiple of 8
OutDataWidth, 64, wide word width in bits; OutDataWidth/InDataWidth (Ratio) must be a power of two >= 2
IdWidth, clog2(NumReq) (derived, localparam), width of the requester ID

Ports:
clk_i  in  1  clock; all state updates on the rising edge
rst_ni  in  1  reset; asynchronous, active-low
req_data_i  in  NumReq x InDataWidth  narrow beat data per requester
req_strb_i  in  NumReq x InDataWidth/8  byte strobes per requester
req_last_i  in  NumReq  the beat is the requester's final beat; flush after it
req_valid_i  in  NumReq  beat valid per requester
req_ready_o  out  NumReq  beat accepted per requester; at most one bit high (one-hot or zero)
data_o  out  OutDataWidth  packed wide word
strb_o  out  OutDataWidth/8  packed strobes
id_o  out  IdWidth  requester that produced data_o
last_o  out  1  the word ends with a beat that had req_last_i set
valid_o  out  1  wide word valid
ready_i  in  1  downstream accepts the wide word

Behaviour:
- Reset values: valid_o=0, req_ready_o=0, data_o=0, strb_o=0, id_o=0, last_o=0; state=Idle, lane count=0, RR pointer=0.
- Reset asserted mid-word: the partial word is dropped and nothing is emitted.
- A narrow beat transfers when req_valid_i[g] && req_ready_o[g] for the granted g.
- The wide word transfers when valid_o && ready_i.
- Requesters must hold data, strobes and last stable while valid is high. This block does not check that.
- State Idle:
  - Pick g = the first i with req_valid_i[i] high, searching from RR pointer upward with wrap.
  - Assert req_ready_o[g] in the same cycle. This is a combinational valid-to-ready path and is allowed.
  - On the transfer: write the beat into lane 0, clear all other lanes (data and strobes to 0), register id=g, count=1.
  - If req_last_i[g] or Ratio==1, go to Send; otherwise go to Collect.
- State Collect:
  - req_ready_o = one-hot(g). The grant is locked: other requesters are ignored even if valid.
  - On a transfer: write the beat into lane count, then count++.
  - Go to Send when the beat fills lane Ratio-1 or carries req_last_i.
  - Idle cycles from g (valid low) are allowed indefinitely with no timeout.
- State Send:
  - valid_o=1 and req_ready_o=0. data_o, strb_o, id_o and last_o are held stable until ready_i.
  - On the handshake: go to Idle, set RR pointer = (g+1) mod NumReq, count=0.
  - No beat is accepted in the handshake cycle.
- Lanes not filled because of an early last keep data=0 and strb=0.
- last_o is the last flag of the final beat only. A full word whose final beat has last set gives last_o=1.
- A beat with strobes all zero still occupies a lane and advances the count.
- Latency: the wide word is valid 1 cycle after the filling or last beat transfers.
- Throughput: at most one full word per Ratio+1 cycles.
- Count width is clog2(Ratio); lane count never wraps, because Send is entered at lane Ratio-1.
- Fairness: a requester that stays valid is granted within NumReq-1 words.

Decomposition:
- apbdma_pkg holds the state_t enum (Idle, Collect, Send; 2 bits) and a ratio/width helper function.
- Sub-module apbdma_rr_pick: combinational, NumReq-wide valid vector plus pointer in, one-hot grant plus index out.
- Packing registers and the state machine stay in the top module.

Test Plan:
- Ratio=2, only req1 sends 0x11111111 then 0x22222222, strobes 0xF, ready_i=1 -> data_o=0x22222222_11111111, strb_o=0xFF, id_o=1, last_o=0, valid_o one cycle after the second beat.
- req2 sends 0xAAAA5555 with last=1 -> data_o=0x00000000_AAAA5555, strb_o=0x0F, last_o=1, id_o=2.
- All four requesters valid continuously, ready_i=1 -> words carry id_o sequence 0,1,2,3,0; each word holds only beats from that requester.
- req0 granted in Collect while req3 is valid -> req_ready_o[3] stays 0 until req0's word handshakes, then req3 is picked next.
- ready_i held low 5 cycles in Send -> valid_o stays 1, outputs stable, all req_ready_o=0; the word is accepted on the first ready_i=1.
- rst_ni pulsed low while in Collect after 1 beat -> valid_o=0 and no word is emitted; the next grant goes to req0 and starts at lane 0.
